// File: rtl/pulse_gen_pkg.sv
// Shared types and constants for the multi-channel pulse train generator.
// Holds the per-channel state encoding, default parameters and shadow reset values.
package pulse_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_PULSE,
        ST_DONE
    } chanState_e;

    localparam int DEF_CHANNELS = 2;
    localparam int DEF_WIDTH    = 15;
    localparam int DEF_BURST_W  = 8;

    // Values the shadows hold after reset, so a start straight out of reset is well defined.
    localparam int RST_PERIOD = 128;
    localparam int RST_WIDTH  = 1;
    localparam int RST_DELAY  = 0;
    localparam int RST_BURST  = 0;

endpackage

// File: rtl/pulse_channel.sv
// One pulse channel: shadowed configuration, start delay, period/burst counting
// and registered pulse/tick outputs.
module pulse_channel
    import pulse_gen_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int BURST_W = DEF_BURST_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               run_i,
    input  logic [WIDTH-1:0]   period_i,
    input  logic [WIDTH-1:0]   width_i,
    input  logic [WIDTH-1:0]   delay_i,
    input  logic [BURST_W-1:0] burst_i,
    output logic               pulse_o,
    output logic               tick_o,
    output logic               done_o,
    output logic               busy_o
);

    localparam logic [WIDTH-1:0]   CntOne   = WIDTH'(1);
    localparam logic [BURST_W-1:0] BurstOne = BURST_W'(1);

    chanState_e         state_q, state_d;
    logic [WIDTH-1:0]   shPeriod_q, shPeriod_d;
    logic [WIDTH-1:0]   shWidth_q, shWidth_d;
    logic [WIDTH-1:0]   shDelay_q, shDelay_d;
    logic [BURST_W-1:0] shBurst_q, shBurst_d;
    logic [WIDTH-1:0]   delayCnt_q, delayCnt_d;
    logic [WIDTH-1:0]   periodCnt_q, periodCnt_d;
    logic [BURST_W-1:0] burstCnt_q, burstCnt_d;
    logic               pulse_q, pulse_d;
    logic               tick_q, tick_d;

    logic [WIDTH-1:0]   lastCnt;
    logic               widthNz;

    // A zero period behaves as a one-cycle period, so the last count is then 0.
    assign lastCnt = (shPeriod_q == '0) ? '0 : (shPeriod_q - CntOne);
    assign widthNz = (shWidth_q != '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            shPeriod_q  <= WIDTH'(RST_PERIOD);
            shWidth_q   <= WIDTH'(RST_WIDTH);
            shDelay_q   <= WIDTH'(RST_DELAY);
            shBurst_q   <= BURST_W'(RST_BURST);
            delayCnt_q  <= '0;
            periodCnt_q <= '0;
            burstCnt_q  <= '0;
            pulse_q     <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shPeriod_q  <= shPeriod_d;
            shWidth_q   <= shWidth_d;
            shDelay_q   <= shDelay_d;
            shBurst_q   <= shBurst_d;
            delayCnt_q  <= delayCnt_d;
            periodCnt_q <= periodCnt_d;
            burstCnt_q  <= burstCnt_d;
            pulse_q     <= pulse_d;
            tick_q      <= tick_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shPeriod_d  = shPeriod_q;
        shWidth_d   = shWidth_q;
        shDelay_d   = shDelay_q;
        shBurst_d   = shBurst_q;
        delayCnt_d  = delayCnt_q;
        periodCnt_d = periodCnt_q;
        burstCnt_d  = burstCnt_q;
        pulse_d     = 1'b0;
        tick_d      = 1'b0;

        if (!run_i) begin
            // Shadows track the inputs whenever run is low, so a one-cycle drop picks up new settings.
            state_d     = ST_IDLE;
            shPeriod_d  = period_i;
            shWidth_d   = width_i;
            shDelay_d   = delay_i;
            shBurst_d   = burst_i;
            delayCnt_d  = '0;
            periodCnt_d = '0;
            burstCnt_d  = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    delayCnt_d  = '0;
                    periodCnt_d = '0;
                    burstCnt_d  = '0;
                    if (shDelay_q != '0) begin
                        state_d = ST_DELAY;
                    end else begin
                        state_d = ST_PULSE;
                        pulse_d = widthNz;
                        tick_d  = 1'b1;
                    end
                end
                ST_DELAY: begin
                    if (delayCnt_q == (shDelay_q - CntOne)) begin
                        state_d     = ST_PULSE;
                        periodCnt_d = '0;
                        pulse_d     = widthNz;
                        tick_d      = 1'b1;
                    end else begin
                        delayCnt_d = delayCnt_q + CntOne;
                    end
                end
                ST_PULSE: begin
                    if (periodCnt_q == lastCnt) begin
                        if ((shBurst_q != '0) && ((burstCnt_q + BurstOne) == shBurst_q)) begin
                            state_d    = ST_DONE;
                            burstCnt_d = burstCnt_q + BurstOne;
                        end else begin
                            periodCnt_d = '0;
                            pulse_d     = widthNz;
                            tick_d      = 1'b1;
                            if (shBurst_q != '0) begin
                                burstCnt_d = burstCnt_q + BurstOne;
                            end
                        end
                    end else begin
                        periodCnt_d = periodCnt_q + CntOne;
                        pulse_d     = ((periodCnt_q + CntOne) < shWidth_q);
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign pulse_o = pulse_q;
    assign tick_o  = tick_q;
    assign done_o  = (state_q == ST_DONE);
    assign busy_o  = (state_q == ST_DELAY) || (state_q == ST_PULSE);

endmodule

// File: rtl/pulse_train_gen.sv
// Multi-channel pulse train generator: one pulse_channel per channel sharing a
// common run enable, with packed configuration buses sliced per channel.
module pulse_train_gen
    import pulse_gen_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int BURST_W  = DEF_BURST_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        run,
    input  logic [CHANNELS*WIDTH-1:0]   pulse_period,
    input  logic [CHANNELS*WIDTH-1:0]   pulse_width,
    input  logic [CHANNELS*WIDTH-1:0]   pulse_delay,
    input  logic [CHANNELS*BURST_W-1:0] burst_count,
    output logic [CHANNELS-1:0]         pulse_out,
    output logic [CHANNELS-1:0]         period_tick,
    output logic [CHANNELS-1:0]         done,
    output logic                        busy
);

    logic [CHANNELS-1:0] chanBusy;

    for (genvar c = 0; c < CHANNELS; c++) begin : gChan
        pulse_channel #(
            .WIDTH   (WIDTH),
            .BURST_W (BURST_W)
        ) uChan (
            .clk_i    (clk),
            .rst_i    (rst),
            .run_i    (run),
            .period_i (pulse_period[c*WIDTH +: WIDTH]),
            .width_i  (pulse_width[c*WIDTH +: WIDTH]),
            .delay_i  (pulse_delay[c*WIDTH +: WIDTH]),
            .burst_i  (burst_count[c*BURST_W +: BURST_W]),
            .pulse_o  (pulse_out[c]),
            .tick_o   (period_tick[c]),
            .done_o   (done[c]),
            .busy_o   (chanBusy[c])
        );
    end

    assign busy = |chanBusy;

endmodule

// File: doc/pulse_train_gen.md
# pulse_train_gen

Multi-channel, parametrised successor to the single-channel PWM pulse generator. Each channel produces a periodic pulse train with its own period, width, start delay (phase offset) and optional burst length, all referenced to a common `run` start. Configuration is shadowed while idle and frozen while running. The block sits between the register/config front end and the external thruster/driver outputs.

## Interface
- `CHANNELS`, default 2: number of independent pulse channels (1..8).
- `WIDTH`, default 15: width of the period, width and delay counters, in cycles.
- `BURST_W`, default 8: width of the burst-count field.
- `clk`  in  1  single system clock; all state changes on its rising edge.
- `rst`  in  1  reset; asynchronous and active-high. All state is cleared immediately on assertion.
- `run`  in  1  level enable; high starts/continues all channels, low aborts and returns to idle.
- `pulse_period`  in  CHANNELS*WIDTH  per-channel period in cycles; channel c occupies bits [c*WIDTH +: WIDTH].
- `pulse_width`  in  CHANNELS*WIDTH  per-channel high time in cycles.
- `pulse_delay`  in  CHANNELS*WIDTH  per-channel cycles from start to the first rising edge.
- `burst_count`  in  CHANNELS*BURST_W  per-channel number of periods; 0 means continuous.
- `pulse_out`  out  CHANNELS  registered pulse outputs.
- `period_tick`  out  CHANNELS  1-cycle strobe at the start of each period.
- `done`  out  CHANNELS  high once a channel's burst has completed; held until `run` falls.
- `busy`  out  1  OR over channels in DELAY or PULSE.

## Operation
- Per-channel state: IDLE, DELAY, PULSE, DONE.
- IDLE: outputs low. Every cycle the shadow registers capture `pulse_period`, `pulse_width`, `pulse_delay` and `burst_count`.
- While `run` is high, the shadows are frozen. Input changes are ignored until the next IDLE.
- IDLE with `run`=1 goes to DELAY if delay>0, or to PULSE if delay=0. The period counter starts at 0 and the burst counter at 0.
- DELAY: the delay counter counts up. It goes to PULSE on the cycle it reaches delay-1, with the period counter at 0.
- PULSE: `pulse_out` = (cnt < width). cnt runs 0..P-1 and then wraps to 0. Each wrap increments the burst counter. When burst_count≠0 and the completed-period count reaches burst_count, the channel goes to DONE instead of wrapping.
- DONE: `pulse_out` low, `done` high, no further ticks.
- `run` low in any state: next edge goes to IDLE, outputs low, counters cleared, `done` cleared.
- Arithmetic and boundary rules:
  - P = max(period, 1).
  - width=0: the output stays low, but ticks and burst counting proceed.
  - width≥P: the output stays continuously high across the period boundary.
  - Counters are WIDTH/BURST_W bits and never wrap beyond P-1 / burst_count.
- Channels are fully independent except for the shared `run`. Different delays give phase offsets relative to the same start edge.

## Timing
- Reset values: `pulse_out`=0, `period_tick`=0, `done`=0, `busy`=0. Shadows reset to period=128, width=1, delay=0, burst=0.
- E0 is the first rising edge sampling `run`=1 in IDLE. Each channel:
  - First rising edge of `pulse_out` is visible after edge E0+D.
  - High for W cycles in every P-cycle window. Edges of period k start at E0+D+k·P.
- `period_tick` is high for the cycle coincident with each period's first `pulse_out` cycle, including the first.
- Burst mode: `done` rises after edge E0+D+N·P, together with `pulse_out` falling if W≥P.
- `busy` rises after E0 and falls after the edge on which the last channel enters DONE or IDLE.
- Abort: `run` sampled low at edge Ek gives all outputs 0 after Ek, regardless of state.
- `rst` asserted mid-operation: outputs go to 0 asynchronously. The first edge after release behaves as IDLE.
- If `run` is high when `rst` releases, the start occurs at the first edge after release, using reset shadow values.

## Structure
- Shared package `pulse_gen_pkg`:
  - channel state enum (IDLE/DELAY/PULSE/DONE);
  - default parameter constants;
  - reset shadow values (128, 1, 0, 0).
- Sub-module `pulse_channel`: one channel FSM with its shadows, delay/period/burst counters and outputs.
- The top instantiates `CHANNELS` copies via generate, slices the packed config buses and ORs the busy signals.

## Test plan
- Reset defaults: `run`=1 immediately after reset, channel 0 → 1-cycle pulse every 128 cycles, tick aligned, `done` never set.
- CH0 P=10 W=3 D=0, CH1 P=10 W=3 D=5, continuous → CH1 rising edges exactly 5 cycles after CH0's, both repeating every 10 cycles.
- P=8 W=2 D=4 N=3 → three pulses at E0+4, +12, +20; `done` rises at E0+28 and holds; `busy` falls on the same edge.
- Edge values: W=0 P=5 → output never high, 5-cycle ticks. W=7 P=5 → constant high. P=0 W=0 → ticks every cycle.
- Change `pulse_period` from 10 to 20 mid-run → output stays at a 10-cycle period. Drop `run` for 1 cycle and raise it again → 20-cycle period from the new start.
- Abort and reset: `run` low during PULSE → outputs 0 next edge. `rst` pulse mid-DELAY → outputs 0 asynchronously and restart with reset shadows.
